// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and the data memory.
package dmem_arbiter_pkg;

    // Word-index width of the 32-entry data memory.
    localparam int unsigned DMEM_ADDR_W = 5;

    // Owner of the memory port in the previous cycle.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LD  = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between MEM stage / loader / data memory and the arbiter.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = 32
);
    // MEM stage side
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    // Loader side
    logic              ld_valid;
    logic              ld_ready;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;
    // Data memory side
    logic [31:0]       mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rd;

    // Arbiter view
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ld_valid, ld_we, ld_addr, ld_wdata,
        input  mem_rd,
        output cpu_stall, ld_ready, ld_rvalid, ld_rdata,
        output mem_a, mem_wd, mem_we
    );

    // Requester / memory view
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ld_valid, ld_we, ld_addr, ld_wdata,
        output mem_rd,
        input  cpu_stall, ld_ready, ld_rvalid, ld_rdata,
        input  mem_a, mem_wd, mem_we
    );
endinterface

// File: rtl/dmem_arbiter_wait_ctr.sv
// Saturating count of consecutive loader denials with clear and at-limit flag.
module dmem_wait_ctr #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic at_max_o
);
    localparam logic [3:0] MaxCnt = 4'(MAX_WAIT);

    logic [3:0] cnt_q, cnt_d;

    // Clear wins; otherwise count up and hold at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (cnt_q != MaxCnt) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MaxCnt);
endmodule

// File: rtl/dmem_arbiter.sv
// CPU-first arbiter for the single-port data memory with a bounded loader wait.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = DMEM_ADDR_W,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);
    owner_e            owner_q, owner_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              gnt_ld;
    logic              wait_at_max;

    // Denials count only while the loader keeps asking and keeps losing.
    dmem_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (gnt_ld || !bus.ld_valid),
        .at_max_o (wait_at_max)
    );

    // Grant decision, memory mux and next-state logic.
    always_comb begin
        gnt_ld = 1'b0;
        if (rst_n && bus.ld_valid) begin
            // Forced grant only after a CPU-owned cycle, so stalls never chain.
            gnt_ld = !bus.cpu_req || (owner_q == OWN_CPU && wait_at_max);
        end

        owner_d  = gnt_ld ? OWN_LD : OWN_CPU;
        rvalid_d = gnt_ld && !bus.ld_we;
        rdata_d  = rvalid_d ? bus.mem_rd : rdata_q;

        bus.ld_ready  = gnt_ld;
        bus.cpu_stall = gnt_ld && bus.cpu_req;
        if (gnt_ld) begin
            bus.mem_a  = {{(32 - ADDR_W){1'b0}}, bus.ld_addr};
            bus.mem_wd = bus.ld_wdata;
            bus.mem_we = bus.ld_we;
        end else begin
            bus.mem_a  = bus.cpu_addr;
            bus.mem_wd = bus.cpu_wdata;
            bus.mem_we = bus.cpu_we && bus.cpu_req && rst_n;
        end
    end

    // Owner and loader read-return registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= OWN_CPU;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            owner_q  <= owner_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.ld_rvalid = rvalid_q;
    assign bus.ld_rdata  = rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    dmem_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W   (5),
        .DATA_W   (32),
        .MAX_WAIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Data memory: word 0 always reads zero.
    logic [31:0] mem [32];
    assign bus.mem_rd = (bus.mem_a[4:0] == 5'd0) ? 32'd0 : mem[bus.mem_a[4:0]];

    // Synchronous memory write.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_a[4:0]] <= bus.mem_wd;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 32'd0;
        bus.cpu_wdata = 32'd0;
        bus.ld_valid = 1'b0;
        bus.ld_we = 1'b0;
        bus.ld_addr = 5'd0;
        bus.ld_wdata = 32'd0;

        // Reset values and output gating under reset.
        #2;
        chk("rst_rvalid", 32'(bus.ld_rvalid), 32'd0);
        chk("rst_rdata", bus.ld_rdata, 32'd0);
        bus.ld_valid = 1'b1;
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        #1;
        chk("rst_ready", 32'(bus.ld_ready), 32'd0);
        chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        bus.ld_valid = 1'b0;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Loader write 5, then read 5, CPU idle.
        bus.ld_valid = 1'b1;
        bus.ld_we = 1'b1;
        bus.ld_addr = 5'd5;
        bus.ld_wdata = 32'hDEADBEEF;
        #1;
        chk("t1_wr_ready", 32'(bus.ld_ready), 32'd1);
        chk("t1_wr_stall", 32'(bus.cpu_stall), 32'd0);
        chk("t1_wr_we", 32'(bus.mem_we), 32'd1);
        chk("t1_wr_a", bus.mem_a, 32'd5);
        chk("t1_wr_wd", bus.mem_wd, 32'hDEADBEEF);
        step();
        bus.ld_we = 1'b0;
        #1;
        chk("t1_rd_ready", 32'(bus.ld_ready), 32'd1);
        chk("t1_rd_we", 32'(bus.mem_we), 32'd0);
        chk("t1_rd_norvalid", 32'(bus.ld_rvalid), 32'd0);
        step();
        bus.ld_valid = 1'b0;
        chk("t1_rvalid", 32'(bus.ld_rvalid), 32'd1);
        chk("t1_rdata", bus.ld_rdata, 32'hDEADBEEF);
        step();
        chk("t1_rvalid_pulse", 32'(bus.ld_rvalid), 32'd0);
        chk("t1_rdata_hold", bus.ld_rdata, 32'hDEADBEEF);

        // CPU loads from 3 continuously; loader read of 5 waits 4 cycles.
        bus.cpu_req = 1'b1;
        bus.cpu_addr = 32'd3;
        bus.ld_valid = 1'b1;
        bus.ld_we = 1'b0;
        bus.ld_addr = 5'd5;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_deny%0d_ready", i), 32'(bus.ld_ready), 32'd0);
            chk($sformatf("t2_deny%0d_stall", i), 32'(bus.cpu_stall), 32'd0);
            chk($sformatf("t2_deny%0d_a", i), bus.mem_a, 32'd3);
            step();
        end
        chk("t2_gnt_ready", 32'(bus.ld_ready), 32'd1);
        chk("t2_gnt_stall", 32'(bus.cpu_stall), 32'd1);
        chk("t2_gnt_a", bus.mem_a, 32'd5);
        step();
        chk("t2_c6_ready", 32'(bus.ld_ready), 32'd0);
        chk("t2_c6_stall", 32'(bus.cpu_stall), 32'd0);
        chk("t2_c6_a", bus.mem_a, 32'd3);
        chk("t2_rvalid", 32'(bus.ld_rvalid), 32'd1);
        chk("t2_rdata", bus.ld_rdata, 32'hDEADBEEF);
        bus.ld_valid = 1'b0;
        step();

        // CPU store to 7 beats a fresh loader request.
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 32'd7;
        bus.cpu_wdata = 32'h11;
        bus.ld_valid = 1'b1;
        bus.ld_addr = 5'd7;
        #1;
        chk("t3_ready", 32'(bus.ld_ready), 32'd0);
        chk("t3_we", 32'(bus.mem_we), 32'd1);
        chk("t3_a", bus.mem_a, 32'd7);
        chk("t3_wd", bus.mem_wd, 32'h11);
        step();
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        #1;
        chk("t3_rd_ready", 32'(bus.ld_ready), 32'd1);
        chk("t3_rd_a", bus.mem_a, 32'd7);
        step();
        bus.ld_valid = 1'b0;
        chk("t3_rvalid", 32'(bus.ld_rvalid), 32'd1);
        chk("t3_rdata", bus.ld_rdata, 32'h11);
        step();

        // Loader write to word 0 does not stick.
        bus.ld_valid = 1'b1;
        bus.ld_we = 1'b1;
        bus.ld_addr = 5'd0;
        bus.ld_wdata = 32'h55;
        #1;
        chk("t4_wr_we", 32'(bus.mem_we), 32'd1);
        chk("t4_wr_a", bus.mem_a, 32'd0);
        step();
        bus.ld_we = 1'b0;
        #1;
        chk("t4_rd_ready", 32'(bus.ld_ready), 32'd1);
        step();
        bus.ld_valid = 1'b0;
        chk("t4_rvalid", 32'(bus.ld_rvalid), 32'd1);
        chk("t4_rdata", bus.ld_rdata, 32'd0);
        step();

        // Reset during a granted read drops the read.
        bus.ld_valid = 1'b1;
        bus.ld_we = 1'b0;
        bus.ld_addr = 5'd7;
        #1;
        chk("t5_ready", 32'(bus.ld_ready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(bus.ld_ready), 32'd0);
        bus.ld_valid = 1'b0;
        step();
        chk("t5_rvalid", 32'(bus.ld_rvalid), 32'd0);
        chk("t5_rdata", bus.ld_rdata, 32'd0);
        rst_n = 1'b1;
        bus.cpu_req = 1'b1;
        bus.cpu_addr = 32'd3;
        bus.ld_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_deny%0d_ready", i), 32'(bus.ld_ready), 32'd0);
            step();
        end
        chk("t5_gnt_ready", 32'(bus.ld_ready), 32'd1);
        chk("t5_gnt_stall", 32'(bus.cpu_stall), 32'd1);
        step();
        bus.ld_valid = 1'b0;
        chk("t5_post_rvalid", 32'(bus.ld_rvalid), 32'd1);
        chk("t5_post_rdata", bus.ld_rdata, 32'h11);
        step();

        // Two denials, withdraw, then a full four denials again.
        bus.ld_valid = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t6_pre%0d_ready", i), 32'(bus.ld_ready), 32'd0);
            step();
        end
        bus.ld_valid = 1'b0;
        step();
        bus.ld_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_deny%0d_ready", i), 32'(bus.ld_ready), 32'd0);
            chk($sformatf("t6_deny%0d_stall", i), 32'(bus.cpu_stall), 32'd0);
            step();
        end
        chk("t6_gnt_ready", 32'(bus.ld_ready), 32'd1);
        chk("t6_gnt_stall", 32'(bus.cpu_stall), 32'd1);
        step();
        chk("t6_after_ready", 32'(bus.ld_ready), 32'd0);
        bus.ld_valid = 1'b0;
        bus.cpu_req = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
